// File: rtl/inlier_accumulator_pkg.sv
// Shared types and defaults for the inlier accumulator.
package inlier_accumulator_pkg;

   localparam int DEF_WIDTH       = 32;
   localparam int DEF_COUNT_WIDTH = 16;

   // Counter saturation value at the default counter width.
   localparam logic [DEF_COUNT_WIDTH-1:0] CNT_ALL_ONES = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_e;

endpackage

// File: rtl/inlier_accumulator_compare.sv
// Stage 1: absolute value of the residual and inlier compare, registered
// with an enable. The valid/last sideband travels alongside mag/hit.
module residual_magnitude_compare #(
   parameter int width = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic [width-1:0] residual_i,
   input  logic             carry_i,
   input  logic             last_i,
   input  logic [width-1:0] threshold_i,
   output logic             vld_o,
   output logic             last_o,
   output logic [width-1:0] mag_o,
   output logic             hit_o
);

   logic [width-1:0] mag_d, mag_q;
   logic             hit_d, hit_q;
   logic             vld_q, last_q;

   // Unsigned magnitude: the most negative value maps onto 2^(width-1),
   // which still fits in width unsigned bits.
   always_comb begin
      mag_d = residual_i[width-1] ? ('0 - residual_i) : residual_i;
      hit_d = !carry_i && (mag_d <= threshold_i);
   end

   // Capture the beat only when it is accepted; valid follows the enable.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         vld_q  <= 1'b0;
         last_q <= 1'b0;
         mag_q  <= '0;
         hit_q  <= 1'b0;
      end else begin
         vld_q <= en_i;
         if (en_i) begin
            last_q <= last_i;
            mag_q  <= mag_d;
            hit_q  <= hit_d;
         end
      end
   end

   assign vld_o  = vld_q;
   assign last_o = last_q;
   assign mag_o  = mag_q;
   assign hit_o  = hit_q;

endmodule

// File: rtl/inlier_accumulator.sv
// Inlier accumulator: classifies residuals against a per-batch threshold,
// counts inliers and samples per batch and emits one result beat per batch.
// Optional feature macro: INLIER_ACCUMULATOR_SUM_EN adds inlier_mag_sum.
module inlier_accumulator
   import inlier_accumulator_pkg::*;
#(
   parameter int width       = DEF_WIDTH,
   parameter int count_width = DEF_COUNT_WIDTH
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   ivalid,
   output logic                   iready,
   input  logic                   ilast,
   input  logic [width-1:0]       residual,
   input  logic                   icarry,
   input  logic [width-1:0]       threshold,
   output logic                   ovalid,
   input  logic                   oready,
   output logic [count_width-1:0] inlier_count,
   output logic [count_width-1:0] sample_count,
`ifdef INLIER_ACCUMULATOR_SUM_EN
   output logic [width+count_width-1:0] inlier_mag_sum,
`endif
   output logic                   saturated
);

   localparam logic [count_width-1:0] CNT_MAX = '1;
   localparam logic [count_width-1:0] CNT_ONE = count_width'(1);

   state_e                 state_q, state_d;
   logic                   iready_q, iready_d;
   logic                   ovalid_q, ovalid_d;
   logic [width-1:0]       thr_q, thr_eff;
   logic                   acc, hs;

   logic                   s1_vld, s1_last, s1_hit;
   logic [width-1:0]       s1_mag;

   logic [count_width-1:0] smp_q, smp_d;
   logic [count_width-1:0] inl_q, inl_d;
   logic                   sat_q, sat_d;

   assign acc = ivalid && iready_q;
   assign hs  = ovalid_q && oready;

   // The first beat of a batch compares against the live threshold; later
   // beats use the copy latched on that first beat.
   assign thr_eff = (state_q == IDLE) ? threshold : thr_q;

   residual_magnitude_compare #(.width(width)) u_cmp (
      .clk_i       (clock),
      .rst_ni      (reset),
      .en_i        (acc),
      .residual_i  (residual),
      .carry_i     (icarry),
      .last_i      (ilast),
      .threshold_i (thr_eff),
      .vld_o       (s1_vld),
      .last_o      (s1_last),
      .mag_o       (s1_mag),
      .hit_o       (s1_hit)
   );

   // State register plus registered handshake outputs and threshold latch.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= IDLE;
         iready_q <= 1'b0;
         ovalid_q <= 1'b0;
         thr_q    <= '0;
      end else begin
         state_q  <= state_d;
         iready_q <= iready_d;
         ovalid_q <= ovalid_d;
         if (state_q == IDLE && acc) thr_q <= threshold;
      end
   end

   // Next-state logic; DRAIN waits for the last beat to leave stage 1.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (acc) state_d = ilast ? DRAIN : ACCUM;
         ACCUM: if (acc && ilast) state_d = DRAIN;
         DRAIN: if (s1_vld && s1_last) state_d = HOLD;
         HOLD:  if (oready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from the next state so they are registered.
   always_comb begin
      iready_d = (state_d == IDLE) || (state_d == ACCUM);
      ovalid_d = (state_d == HOLD);
   end

`ifdef INLIER_ACCUMULATOR_SUM_EN
   localparam int SW  = width + count_width;
   localparam int SWX = SW + 1;
   localparam logic [SW-1:0] SUM_MAX = '1;

   logic [SW-1:0]  sum_q, sum_d;
   logic [SWX-1:0] sum_ext;

   assign sum_ext = {1'b0, sum_q} + SWX'(s1_mag);
`endif

   // Stage 2 next-state: saturating counters, sticky saturation flag.
   always_comb begin
      smp_d = smp_q;
      inl_d = inl_q;
      sat_d = sat_q;
`ifdef INLIER_ACCUMULATOR_SUM_EN
      sum_d = sum_q;
`endif
      if (hs) begin
         smp_d = '0;
         inl_d = '0;
         sat_d = 1'b0;
`ifdef INLIER_ACCUMULATOR_SUM_EN
         sum_d = '0;
`endif
      end else if (s1_vld) begin
         if (smp_q != CNT_MAX) smp_d = smp_q + CNT_ONE;
         if (s1_hit && inl_q != CNT_MAX) inl_d = inl_q + CNT_ONE;
         if (smp_d == CNT_MAX || inl_d == CNT_MAX) sat_d = 1'b1;
`ifdef INLIER_ACCUMULATOR_SUM_EN
         if (s1_hit) sum_d = sum_ext[SW] ? SUM_MAX : sum_ext[SW-1:0];
         if (sum_d == SUM_MAX) sat_d = 1'b1;
`endif
      end
   end

   // Stage 2 registers; these are the result outputs held through HOLD.
   always_ff @(posedge clock) begin
      if (!reset) begin
         smp_q <= '0;
         inl_q <= '0;
         sat_q <= 1'b0;
`ifdef INLIER_ACCUMULATOR_SUM_EN
         sum_q <= '0;
`endif
      end else begin
         smp_q <= smp_d;
         inl_q <= inl_d;
         sat_q <= sat_d;
`ifdef INLIER_ACCUMULATOR_SUM_EN
         sum_q <= sum_d;
`endif
      end
   end

   assign iready       = iready_q;
   assign ovalid       = ovalid_q;
   assign inlier_count = inl_q;
   assign sample_count = smp_q;
   assign saturated    = sat_q;
`ifdef INLIER_ACCUMULATOR_SUM_EN
   assign inlier_mag_sum = sum_q;
`endif

endmodule

// File: tb/tb_inlier_accumulator.sv
// Randomized bench for inlier_accumulator (width=8, count_width=4) with a
// per-batch reference model computed from the classification rules.
`timescale 1ns/1ps
module tb_inlier_accumulator;

   localparam int W      = 8;
   localparam int CW     = 4;
   localparam int CMAX   = 15;
   localparam int SUMMAX = 4095;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          ivalid = 1'b0, ilast = 1'b0, icarry = 1'b0, oready = 1'b0;
   logic [W-1:0]  residual = '0, threshold = '0;
   logic          iready, ovalid, saturated;
   logic [CW-1:0] inlier_count, sample_count;
`ifdef INLIER_ACCUMULATOR_SUM_EN
   logic [W+CW-1:0] inlier_mag_sum;
`endif

   inlier_accumulator #(.width(W), .count_width(CW)) dut (
      .clock        (clock),
      .reset        (reset),
      .ivalid       (ivalid),
      .iready       (iready),
      .ilast        (ilast),
      .residual     (residual),
      .icarry       (icarry),
      .threshold    (threshold),
      .ovalid       (ovalid),
      .oready       (oready),
      .inlier_count (inlier_count),
      .sample_count (sample_count),
`ifdef INLIER_ACCUMULATOR_SUM_EN
      .inlier_mag_sum (inlier_mag_sum),
`endif
      .saturated    (saturated)
   );

   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_pass = 0;

   // Current batch description.
   int  bres [64];
   bit  bcar [64];
   int  blen;
   int  bthr;
   int  bnum = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL b%0d %s: got %0d expected %0d", bnum, tag, got, exp);
   endtask

   // Expected result for the current batch.
   task automatic model(output int ei, output int es, output int esum, output bit esat);
      int m;
      ei = 0; es = 0; esum = 0;
      for (int k = 0; k < blen; k++) begin
         m = (bres[k] < 0) ? -bres[k] : bres[k];
         es++;
         if (!bcar[k] && m <= bthr) begin
            ei++;
            esum += m;
         end
      end
      esat = (es >= CMAX) || (ei >= CMAX);
`ifdef INLIER_ACCUMULATOR_SUM_EN
      esat = esat || (esum >= SUMMAX);
`endif
      if (es > CMAX) es = CMAX;
      if (ei > CMAX) ei = CMAX;
      if (esum > SUMMAX) esum = SUMMAX;
   endtask

   // Drive one batch with random bubbles, check latency, hold, handshake.
   task automatic run_batch(input int hold);
      int ei, es, esum, i, cyc;
      bit esat, acc;
      bnum++;
      model(ei, es, esum, esat);
      i = 0; cyc = 0;
      @(negedge clock);
      while (i < blen && cyc < 400) begin
         if ($urandom_range(3) == 0) begin
            ivalid = 1'b0;
         end else begin
            ivalid    = 1'b1;
            residual  = W'(bres[i]);
            icarry    = bcar[i];
            ilast     = (i == blen - 1);
            threshold = (i == 0) ? W'(bthr) : W'($urandom);
         end
         acc = ivalid && iready;
         @(negedge clock);
         if (acc) i++;
         cyc++;
      end
      ivalid = 1'b0;
      ilast  = 1'b0;
      if (i < blen) begin
         chk("accept_timeout", i, blen);
         return;
      end
      chk("drain_ovalid", int'(ovalid), 0);
      chk("drain_iready", int'(iready), 0);
      @(negedge clock);
      chk("ovalid", int'(ovalid), 1);
      chk("inlier_count", int'(inlier_count), ei);
      chk("sample_count", int'(sample_count), es);
      chk("saturated", int'(saturated), int'(esat));
`ifdef INLIER_ACCUMULATOR_SUM_EN
      chk("inlier_mag_sum", int'(inlier_mag_sum), esum);
`endif
      for (int k = 0; k < hold; k++) begin
         @(negedge clock);
         chk("hold_ovalid", int'(ovalid), 1);
         chk("hold_iready", int'(iready), 0);
         chk("hold_inlier", int'(inlier_count), ei);
         chk("hold_sample", int'(sample_count), es);
      end
      oready = 1'b1;
      @(negedge clock);
      oready = 1'b0;
      chk("post_hs_ovalid", int'(ovalid), 0);
      chk("post_hs_iready", int'(iready), 1);
      chk("post_hs_sample", int'(sample_count), 0);
      chk("post_hs_inlier", int'(inlier_count), 0);
      chk("post_hs_sat", int'(saturated), 0);
   endtask

   initial begin
      int i, cyc;
      bit acc;

      // Reset state.
      repeat (3) @(negedge clock);
      chk("rst_iready", int'(iready), 0);
      chk("rst_ovalid", int'(ovalid), 0);
      chk("rst_inlier", int'(inlier_count), 0);
      chk("rst_sample", int'(sample_count), 0);
      chk("rst_sat", int'(saturated), 0);
      reset = 1'b1;
      @(negedge clock);
      chk("rst_rel_iready", int'(iready), 1);

      // Mixed batch: 3 inliers of 5 samples, long HOLD.
      bthr = 5; blen = 5;
      bres[0] = 3; bres[1] = -5; bres[2] = 6; bres[3] = -128; bres[4] = 0;
      for (int k = 0; k < 5; k++) bcar[k] = 1'b0;
      run_batch(10);

      // Carry marks an otherwise in-range residual as outlier.
      blen = 3; bres[0] = 2; bres[1] = 1; bres[2] = 7;
      bcar[0] = 1'b1; bcar[1] = 1'b0; bcar[2] = 1'b0;
      run_batch(0);

      // Counter saturation.
      blen = 20;
      for (int k = 0; k < 20; k++) begin bres[k] = 1; bcar[k] = 1'b0; end
      run_batch(1);

      // Magnitude sum of inliers.
      blen = 3; bres[0] = 3; bres[1] = -5; bres[2] = 6;
      for (int k = 0; k < 3; k++) bcar[k] = 1'b0;
      run_batch(0);

      // Single-beat batch.
      blen = 1; bres[0] = -4; bcar[0] = 1'b0; bthr = 4;
      run_batch(2);

      // Reset in the middle of a batch discards it.
      i = 0; cyc = 0;
      @(negedge clock);
      while (i < 3 && cyc < 100) begin
         ivalid = 1'b1; residual = W'(1); icarry = 1'b0; ilast = 1'b0;
         threshold = W'(5);
         acc = ivalid && iready;
         @(negedge clock);
         if (acc) i++;
         cyc++;
      end
      ivalid = 1'b0;
      reset  = 1'b0;
      @(negedge clock);
      chk("midrst_iready", int'(iready), 0);
      chk("midrst_ovalid", int'(ovalid), 0);
      chk("midrst_sample", int'(sample_count), 0);
      reset = 1'b1;
      @(negedge clock);
      chk("midrst_rel_iready", int'(iready), 1);
      chk("midrst_rel_ovalid", int'(ovalid), 0);
      blen = 2; bthr = 5; bres[0] = 4; bres[1] = -9; bcar[0] = 1'b0; bcar[1] = 1'b0;
      run_batch(0);

      // Random batches.
      for (int b = 0; b < 15; b++) begin
         blen = $urandom_range(1, 18);
         bthr = $urandom_range(0, 140);
         for (int k = 0; k < blen; k++) begin
            bres[k] = $urandom_range(0, 255) - 128;
            bcar[k] = ($urandom_range(7) == 0);
         end
         run_batch($urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
